hazard_controller: RTL and testbench

- Pipeline hazard sequencer for the 5-stage MIPS core. It works alongside the EX-stage forwarding logic.
- Detects load-use hazards and inserts a programmable number of bubbles.
- Flushes IF/ID and ID/EX on a taken branch.
- Freezes the whole pipeline while the data memory handshake is outstanding, with a timeout that raises a sticky error.
- Drives the PC, IF/ID and ID/EX write/flush controls and a stall-cycle counter.

---
 rtl/hazard_pkg.sv | 15 +
 rtl/hazard_detect.sv | 23 ++
 rtl/hazard_controller.sv | 189 ++++++++++++++++++
 tb/tb_hazard_controller.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard sequencer.
//   hz_state_t : sequencer states
//   ZERO_REG   : architectural zero register, never a real dependency
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BUBBLE   = 2'd1,
    MEM_WAIT = 2'd2,
    ERROR    = 2'd3
  } hz_state_t;

  localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags when the load sitting in EX writes a register
// that the instruction in ID reads.
// Ports:
//   id_ex_mem_read_i : instruction in EX is a load
//   id_ex_rt_i       : load destination register
//   if_id_rs_i       : Rs of the instruction in ID
//   if_id_rt_i       : Rt of the instruction in ID
//   load_use_o       : a bubble is needed
module hazard_detect
  import hazard_pkg::*;
(
  input  logic       id_ex_mem_read_i,
  input  logic [4:0] id_ex_rt_i,
  input  logic [4:0] if_id_rs_i,
  input  logic [4:0] if_id_rt_i,
  output logic       load_use_o
);

  // Writes to $zero are discarded, so they never create a dependency.
  assign load_use_o = id_ex_mem_read_i && (id_ex_rt_i != ZERO_REG) &&
                      ((id_ex_rt_i == if_id_rs_i) || (id_ex_rt_i == if_id_rt_i));

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard sequencer for the 5-stage core: load-use bubbles, branch
// flushes and a memory-handshake freeze with a sticky timeout error.
// Ports:
//   clk, rst              : clock, async active-low reset
//   ifIdRs/ifIdRt/idExRt  : register numbers for load-use detection
//   idExMemRead           : EX holds a load
//   branchTaken           : branch resolved taken this cycle
//   memReq/memReady       : data memory handshake
//   pcWrite/ifIdWrite     : front-end enables
//   ifIdFlush/idExFlush   : bubble insertion
//   pipeHold              : hold ID/EX, EX/MEM, MEM/WB
//   memErr                : sticky memory timeout
//   stallCount            : saturating count of cycles with pcWrite=0
//
// state    | meaning
// ---------+----------------------------------------------------
// RUN      | normal flow; detects stalls, flushes and load-use
// BUBBLE   | inserting the remaining load-use bubbles
// MEM_WAIT | frozen until memReady; resumes the saved state
// ERROR    | memory timed out; frozen until reset
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int LOAD_STALL  = 1,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ifIdRs,
  input  logic [4:0]       ifIdRt,
  input  logic [4:0]       idExRt,
  input  logic             idExMemRead,
  input  logic             branchTaken,
  input  logic             memReq,
  input  logic             memReady,
  output logic             pcWrite,
  output logic             ifIdWrite,
  output logic             ifIdFlush,
  output logic             idExFlush,
  output logic             pipeHold,
  output logic             memErr,
  output logic [CNT_W-1:0] stallCount
);

  // First bubble is issued from RUN, so the counter holds the remainder.
  localparam logic [2:0] BUB_INIT = 3'(LOAD_STALL - 1);
  localparam logic [7:0] WAIT_MAX = 8'(MEM_TIMEOUT);

  hz_state_t        state_q, state_d;
  hz_state_t        resume_q, resume_d;
  logic [2:0]       bub_q, bub_d;
  logic [7:0]       wait_q, wait_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             load_use;
  logic             mem_stall;

  hazard_detect u_detect (
    .id_ex_mem_read_i (idExMemRead),
    .id_ex_rt_i       (idExRt),
    .if_id_rs_i       (ifIdRs),
    .if_id_rt_i       (ifIdRt),
    .load_use_o       (load_use)
  );

  assign mem_stall = memReq && !memReady;

  always_comb begin
    pcWrite   = 1'b1;
    ifIdWrite = 1'b1;
    ifIdFlush = 1'b0;
    idExFlush = 1'b0;
    pipeHold  = 1'b0;
    state_d   = state_q;
    resume_d  = resume_q;
    bub_d     = bub_q;
    wait_d    = wait_q;
    err_d     = err_q;

    case (state_q)
      RUN: begin
        if (mem_stall) begin
          pcWrite   = 1'b0;
          ifIdWrite = 1'b0;
          pipeHold  = 1'b1;
          resume_d  = RUN;
          wait_d    = 8'd1;
          state_d   = MEM_WAIT;
        end else if (branchTaken) begin
          ifIdFlush = 1'b1;
          idExFlush = 1'b1;
        end else if (load_use) begin
          pcWrite   = 1'b0;
          ifIdWrite = 1'b0;
          idExFlush = 1'b1;
          if (BUB_INIT != 3'd0) begin
            bub_d   = BUB_INIT;
            state_d = BUBBLE;
          end
        end
      end
      BUBBLE: begin
        if (mem_stall) begin
          pcWrite   = 1'b0;
          ifIdWrite = 1'b0;
          pipeHold  = 1'b1;
          resume_d  = BUBBLE;
          wait_d    = 8'd1;
          state_d   = MEM_WAIT;
        end else if (branchTaken) begin
          // The flush already removes the dependent instruction.
          ifIdFlush = 1'b1;
          idExFlush = 1'b1;
          bub_d     = 3'd0;
          state_d   = RUN;
        end else begin
          pcWrite   = 1'b0;
          ifIdWrite = 1'b0;
          idExFlush = 1'b1;
          bub_d     = bub_q - 3'd1;
          if (bub_q <= 3'd1) begin
            bub_d   = 3'd0;
            state_d = RUN;
          end
        end
      end
      MEM_WAIT: begin
        if (memReady) begin
          wait_d  = 8'd0;
          state_d = resume_q;
        end else begin
          pcWrite   = 1'b0;
          ifIdWrite = 1'b0;
          pipeHold  = 1'b1;
          if (wait_q == WAIT_MAX) begin
            err_d   = 1'b1;
            state_d = ERROR;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end
      end
      ERROR: begin
        pcWrite   = 1'b0;
        ifIdWrite = 1'b0;
        pipeHold  = 1'b1;
        err_d     = 1'b1;
      end
      default: state_d = RUN;
    endcase

    // Keep the pipeline running normally while reset is held.
    if (!rst) begin
      pcWrite   = 1'b1;
      ifIdWrite = 1'b1;
      ifIdFlush = 1'b0;
      idExFlush = 1'b0;
      pipeHold  = 1'b0;
    end

    stall_cnt_d = stall_cnt_q;
    if (!pcWrite && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      resume_q    <= RUN;
      bub_q       <= 3'd0;
      wait_q      <= 8'd0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      resume_q    <= resume_d;
      bub_q       <= bub_d;
      wait_q      <= wait_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign memErr     = err_q;
  assign stallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller. Two instances share the stimulus:
//   dut_a : LOAD_STALL=1, MEM_TIMEOUT=15,  CNT_W=16
//   dut_b : LOAD_STALL=3, MEM_TIMEOUT=255, CNT_W=4
// Each cycle's expected outputs are queued when the inputs are driven and
// compared against the selected instance once the outputs settle.
module tb_hazard_controller;

  localparam logic [4:0] DEF = 5'b11000;  // {pcWrite,ifIdWrite,ifIdFlush,idExFlush,pipeHold}
  localparam logic [4:0] LU  = 5'b00010;
  localparam logic [4:0] FRZ = 5'b00001;
  localparam logic [4:0] BRF = 5'b11110;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] ifIdRs = '0, ifIdRt = '0, idExRt = '0;
  logic       idExMemRead = 1'b0, branchTaken = 1'b0, memReq = 1'b0, memReady = 1'b0;

  logic        pcw_a, ifw_a, iff_a, idf_a, hold_a, err_a;
  logic [15:0] cnt_a;
  logic        pcw_b, ifw_b, iff_b, idf_b, hold_b, err_b;
  logic [3:0]  cnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit         sel;   // 0: dut_a, 1: dut_b
    logic [4:0] ctl;
    logic       err;
    int         cnt;
    string      tag;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  hazard_controller #(.LOAD_STALL(1), .MEM_TIMEOUT(15), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .ifIdRs(ifIdRs), .ifIdRt(ifIdRt), .idExRt(idExRt),
    .idExMemRead(idExMemRead), .branchTaken(branchTaken), .memReq(memReq),
    .memReady(memReady), .pcWrite(pcw_a), .ifIdWrite(ifw_a), .ifIdFlush(iff_a),
    .idExFlush(idf_a), .pipeHold(hold_a), .memErr(err_a), .stallCount(cnt_a)
  );

  hazard_controller #(.LOAD_STALL(3), .MEM_TIMEOUT(255), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .ifIdRs(ifIdRs), .ifIdRt(ifIdRt), .idExRt(idExRt),
    .idExMemRead(idExMemRead), .branchTaken(branchTaken), .memReq(memReq),
    .memReady(memReady), .pcWrite(pcw_b), .ifIdWrite(ifw_b), .ifIdFlush(iff_b),
    .idExFlush(idf_b), .pipeHold(hold_b), .memErr(err_b), .stallCount(cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    ifIdRs = '0; ifIdRt = '0; idExRt = '0;
    idExMemRead = 1'b0; branchTaken = 1'b0; memReq = 1'b0; memReady = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".a.ctl"}, {27'd0, pcw_a, ifw_a, iff_a, idf_a, hold_a}, {27'd0, DEF});
    chk({tag, ".a.err"}, {31'd0, err_a}, 32'd0);
    chk({tag, ".a.cnt"}, {16'd0, cnt_a}, 32'd0);
    chk({tag, ".b.ctl"}, {27'd0, pcw_b, ifw_b, iff_b, idf_b, hold_b}, {27'd0, DEF});
    chk({tag, ".b.cnt"}, {28'd0, cnt_b}, 32'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    #1;
    check_idle(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic step(input string tag, input bit sel,
                      input logic mreq, input logic mrdy, input logic br, input logic ld,
                      input logic [4:0] rt_ex, input logic [4:0] rs, input logic [4:0] rt_id,
                      input logic [4:0] ctl, input logic err, input int cnt);
    exp_t e;
    logic [4:0]  o_ctl;
    logic        o_err;
    logic [31:0] o_cnt;
    @(negedge clk);
    memReq = mreq; memReady = mrdy; branchTaken = br; idExMemRead = ld;
    idExRt = rt_ex; ifIdRs = rs; ifIdRt = rt_id;
    e.sel = sel; e.ctl = ctl; e.err = err; e.cnt = cnt; e.tag = tag;
    sb_q.push_back(e);
    #1;
    e = sb_q.pop_front();
    if (e.sel) begin
      o_ctl = {pcw_b, ifw_b, iff_b, idf_b, hold_b};
      o_err = err_b;
      o_cnt = {28'd0, cnt_b};
    end else begin
      o_ctl = {pcw_a, ifw_a, iff_a, idf_a, hold_a};
      o_err = err_a;
      o_cnt = {16'd0, cnt_a};
    end
    chk({e.tag, ".ctl"}, {27'd0, o_ctl}, {27'd0, e.ctl});
    chk({e.tag, ".err"}, {31'd0, o_err}, {31'd0, e.err});
    chk({e.tag, ".cnt"}, o_cnt, e.cnt);
  endtask

  initial begin
    // Reset values, including outputs while reset is held.
    #1;
    check_idle("rst0");
    @(negedge clk);
    rst = 1'b1;

    // Load-use, single bubble (dut_a).
    step("ls1.rs",   0, 0,0,0,1, 5'd8, 5'd8, 5'd3, LU,  0, 0);
    step("ls1.clr",  0, 0,0,0,0, 5'd0, 5'd0, 5'd0, DEF, 0, 1);
    step("ls1.rt",   0, 0,0,0,1, 5'd8, 5'd3, 5'd8, LU,  0, 1);
    step("ls1.clr2", 0, 0,0,0,0, 5'd0, 5'd0, 5'd0, DEF, 0, 2);
    step("ls1.zero", 0, 0,0,0,1, 5'd0, 5'd0, 5'd0, DEF, 0, 2);
    step("ls1.nom",  0, 0,0,0,1, 5'd8, 5'd9, 5'd7, DEF, 0, 2);

    // Load-use, three bubbles (dut_b).
    do_reset("rst1");
    step("ls3.b1",   1, 0,0,0,1, 5'd8, 5'd8, 5'd0, LU,  0, 0);
    step("ls3.b2",   1, 0,0,0,0, 5'd0, 5'd0, 5'd0, LU,  0, 1);
    step("ls3.b3",   1, 0,0,0,0, 5'd0, 5'd0, 5'd0, LU,  0, 2);
    step("ls3.run",  1, 0,0,0,0, 5'd0, 5'd0, 5'd0, DEF, 0, 3);
    step("ls3.zero", 1, 0,0,0,1, 5'd0, 5'd0, 5'd0, DEF, 0, 3);
    // Taken branch cuts the bubble sequence short.
    step("ls3.c1",   1, 0,0,0,1, 5'd8, 5'd8, 5'd0, LU,  0, 3);
    step("ls3.br",   1, 0,0,1,0, 5'd0, 5'd0, 5'd0, BRF, 0, 4);
    step("ls3.brx",  1, 0,0,0,0, 5'd0, 5'd0, 5'd0, DEF, 0, 4);
    // Memory stall during BUBBLE resumes the remaining bubbles.
    step("ls3.m1",   1, 0,0,0,1, 5'd8, 5'd8, 5'd0, LU,  0, 4);
    step("ls3.mw1",  1, 1,0,0,0, 5'd0, 5'd0, 5'd0, FRZ, 0, 5);
    step("ls3.mw2",  1, 1,0,0,0, 5'd0, 5'd0, 5'd0, FRZ, 0, 6);
    step("ls3.mrdy", 1, 1,1,0,0, 5'd0, 5'd0, 5'd0, DEF, 0, 7);
    step("ls3.rb2",  1, 0,0,0,0, 5'd0, 5'd0, 5'd0, LU,  0, 7);
    step("ls3.rb3",  1, 0,0,0,0, 5'd0, 5'd0, 5'd0, LU,  0, 8);
    step("ls3.end",  1, 0,0,0,0, 5'd0, 5'd0, 5'd0, DEF, 0, 9);

    // Memory wait with a branch pulse inside it (dut_a).
    do_reset("rst2");
    step("mw.1",   0, 1,0,0,0, 5'd0, 5'd0, 5'd0, FRZ, 0, 0);
    step("mw.2br", 0, 1,0,1,1, 5'd4, 5'd4, 5'd0, FRZ, 0, 1);
    step("mw.3",   0, 1,0,0,0, 5'd0, 5'd0, 5'd0, FRZ, 0, 2);
    step("mw.4",   0, 1,0,0,0, 5'd0, 5'd0, 5'd0, FRZ, 0, 3);
    step("mw.rdy", 0, 1,1,0,0, 5'd0, 5'd0, 5'd0, DEF, 0, 4);
    step("mw.idl", 0, 0,0,0,0, 5'd0, 5'd0, 5'd0, DEF, 0, 4);
    // Priority: memStall over branch over load-use.
    step("pri.all", 0, 1,0,1,1, 5'd6, 5'd6, 5'd0, FRZ, 0, 4);
    step("pri.rdy", 0, 1,1,0,0, 5'd0, 5'd0, 5'd0, DEF, 0, 5);
    step("pri.blu", 0, 0,0,1,1, 5'd6, 5'd0, 5'd6, BRF, 0, 5);
    step("pri.hit", 0, 1,1,0,0, 5'd0, 5'd0, 5'd0, DEF, 0, 5);

    // Timeout and sticky error (dut_a).
    do_reset("rst3");
    for (int i = 0; i < 16; i++)
      step($sformatf("to.w%0d", i), 0, 1,0,0,0, 5'd0, 5'd0, 5'd0, FRZ, 0, i);
    step("to.err",  0, 1,0,0,0, 5'd0, 5'd0, 5'd0, FRZ, 1, 16);
    step("to.stk",  0, 1,1,1,1, 5'd2, 5'd2, 5'd0, FRZ, 1, 17);
    // Asynchronous reset while in ERROR, inputs still active.
    #2;
    rst = 1'b0;
    #1;
    chk("to.arst.ctl", {27'd0, pcw_a, ifw_a, iff_a, idf_a, hold_a}, {27'd0, DEF});
    chk("to.arst.err", {31'd0, err_a}, 32'd0);
    chk("to.arst.cnt", {16'd0, cnt_a}, 32'd0);
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
    step("to.run",  0, 0,0,0,0, 5'd0, 5'd0, 5'd0, DEF, 0, 0);
    step("to.br",   0, 0,0,1,0, 5'd0, 5'd0, 5'd0, BRF, 0, 0);
    step("to.lu",   0, 0,0,0,1, 5'd5, 5'd5, 5'd0, LU,  0, 0);

    // Stall counter saturation at 4 bits (dut_b, long timeout).
    do_reset("rst4");
    for (int i = 0; i < 21; i++)
      step($sformatf("sat.%0d", i), 1, 1,0,0,0, 5'd0, 5'd0, 5'd0, FRZ, 0, (i < 15) ? i : 15);
    step("sat.rdy", 1, 1,1,0,0, 5'd0, 5'd0, 5'd0, DEF, 0, 15);
    step("sat.hld", 1, 0,0,0,0, 5'd0, 5'd0, 5'd0, DEF, 0, 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
